// File: rtl/otter_mdu_iterative.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// A radix-2 shift-add multiplier and a restoring divider share one 64-bit
// working register. Both work on operand magnitudes, and the sign is applied
// once on the final step. Division by zero and signed overflow are resolved
// when the operation is accepted.
module otter_mdu_iterative #(
    parameter int WIDTH        = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [2:0]         op_q;
    logic               neg_q;
    logic               special_q;
    logic [WIDTH-1:0]   mag_b_q;
    // Multiply: {partial high, multiplier bits}. Divide: {remainder, quotient/dividend}.
    logic [2*WIDTH-1:0] acc;

    // Accept-time decode: operand signs, magnitudes and the special cases.
    logic             is_div, a_signed, b_signed, sa, sb;
    logic             div_zero, div_ovf, special, neg_in;
    logic [WIDTH-1:0] mag_a, mag_b, spec_val;

    // Operand decode for the request that is currently on the inputs.
    // NOTE: every signal is assigned on every path here, so no latch is inferred.
    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
        b_signed = is_div ? ~funct3[0] : (funct3 == 3'b001);
        sa       = a_signed & srcA[WIDTH-1];
        sb       = b_signed & srcB[WIDTH-1];
        mag_a    = sa ? -srcA : srcA;
        mag_b    = sb ? -srcB : srcB;
        div_zero = is_div && (srcB == '0);
        div_ovf  = is_div && !funct3[0] && (srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (srcB == '1);
        special  = div_zero | div_ovf;
        // The remainder takes the dividend's sign; every other result takes sa^sb.
        neg_in   = (is_div && funct3[1]) ? sa : (sa ^ sb);
        if (div_zero)
            spec_val = funct3[1] ? srcA : '1;
        else if (funct3[1])
            spec_val = '0;
        else
            spec_val = {1'b1, {(WIDTH-1){1'b0}}};
    end

    // One iteration step and the signed result that the last step produces.
    logic [WIDTH:0]     mul_sum, rem_shift;
    logic [WIDTH-1:0]   rem_diff, word, word_s, fin_val;
    logic               rem_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, acc_next, prod_s;

    // Datapath step: add-shift for multiply, trial subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b_q} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, mag_b_q};
        // When rem_ge is set the difference is below the divisor, so the low bits are exact.
        rem_diff  = rem_shift[WIDTH-1:0] - mag_b_q;
        div_next  = rem_ge ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                           : {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        // The special-case value sits in acc and holds while the counter runs out.
        acc_next  = special_q ? acc : (op_q[2] ? div_next : mul_next);
        prod_s    = neg_q ? -acc_next : acc_next;
        word      = op_q[1] ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
        word_s    = neg_q ? -word : word;
        if (special_q)
            fin_val = acc_next[WIDTH-1:0];
        else if (op_q[2])
            fin_val = word_s;
        else if (op_q[1:0] == 2'b00)
            fin_val = prod_s[WIDTH-1:0];
        else
            fin_val = prod_s[2*WIDTH-1:WIDTH];
    end

    // Control FSM plus the operand and result registers. Flush wins over everything.
    // NOTE: non-blocking assignments keep every register update tied to the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            count     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            mag_b_q   <= '0;
            acc       <= '0;
            result    <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q      <= funct3;
                    neg_q     <= neg_in;
                    special_q <= special;
                    mag_b_q   <= mag_b;
                    count     <= '0;
                    if (special && FAST_SPECIAL) begin
                        state  <= FIN;
                        result <= spec_val;
                    end else begin
                        state <= RUN;
                        acc   <= special ? {{WIDTH{1'b0}}, spec_val} : {{WIDTH{1'b0}}, mag_a};
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == CNT_LAST) begin
                        state  <= FIN;
                        result <= fin_val;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == FIN);
    // A flush during FIN cancels that cycle's done pulse.
    assign done = (state == FIN) && !flush;

endmodule

// File: tb/tb_otter_mdu_iterative.sv
// Self-checking bench for otter_mdu_iterative. Each accepted request pushes its
// expected result and completion cycle into a queue. A monitor pops one entry
// on every done pulse. Expected values come from plain RV32M arithmetic.
module tb_otter_mdu_iterative;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        busy, done;
    logic [31:0] result;

    otter_mdu_iterative #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .flush(flush), .funct3(funct3),
        .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .result(result)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // RV32M semantics with 64-bit host arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sbv = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        int          ia = $signed(a);
        int          ib = $signed(b);
        logic [63:0] prod;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin prod = 64'(ua * ub);  return prod[31:0];  end
            3'd1: begin prod = 64'(sa * sbv); return prod[63:32]; end
            3'd2: begin prod = 64'(sa * ub);  return prod[63:32]; end
            3'd3: begin prod = 64'(ua * ub);  return prod[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Waits for the unit to go idle, then presents one request for one cycle.
    // On return the bench is at the falling edge of cycle 1 of that request.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit track);
        exp_t e;
        int   guard = 0;
        @(negedge CLK);
        while (busy && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: busy still %b after %0d cycles, expected 0", busy, guard);
        end
        start  = 1'b1;
        funct3 = f3;
        srcA   = a;
        srcB   = b;
        if (track) begin
            e.f3  = f3;
            e.a   = a;
            e.b   = b;
            e.exp = ref_result(f3, a, b);
            e.due = cyc + ref_latency(f3, a, b);
            last_exp = e.exp;
            sb_q.push_back(e);
        end
        @(negedge CLK);
        start  = 1'b0;
        funct3 = 3'($urandom);
        srcA   = $urandom;
        srcB   = $urandom;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge CLK) begin
        if (RST_N && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: result %h at cycle %0d, expected no done", result, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("result f3=%0d a=%h b=%h", mon_e.f3, mon_e.a, mon_e.b),
                      result, mon_e.exp);
                check($sformatf("done_cycle f3=%0d a=%h b=%h", mon_e.f3, mon_e.a, mon_e.b),
                      32'(cyc), 32'(mon_e.due));
            end
        end
    end

    initial begin
        int guard;
        logic [2:0] rf3;

        // Asynchronous reset, with outputs checked while reset is held.
        #2 RST_N = 1'b0;
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;

        // MUL with busy-window checks.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        check("busy_cycle1", {31'b0, busy}, 32'd1);
        repeat (32) @(negedge CLK);
        check("busy_cycle33", {31'b0, busy}, 32'd1);
        check("done_cycle33", {31'b0, done}, 32'd1);
        @(negedge CLK);
        check("busy_cycle34", {31'b0, busy}, 32'd0);
        check("result_hold", result, 32'hFFFF_FFEB);

        // Directed high-half multiplies, divides and special cases, issued back-to-back.
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(3'd5, 32'd100, 32'd7, 1'b1);
        issue(3'd7, 32'd100, 32'd7, 1'b1);
        issue(3'd5, 32'd5, 32'd0, 1'b1);
        issue(3'd7, 32'd5, 32'd0, 1'b1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(3'd4, 32'h8000_0000, 32'd0, 1'b1);

        // A second start while busy must be ignored.
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        repeat (5) @(negedge CLK);
        start = 1'b1; funct3 = 3'd0; srcA = 32'd1; srcB = 32'd1;
        @(negedge CLK);
        start = 1'b0;

        // Flush in the middle of a divide: no done, result keeps its previous value.
        issue(3'd4, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_result", result, last_exp);

        // Start together with flush while idle is dropped.
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; srcA = 32'd9; srcB = 32'd0;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        check("start_flush_idle_busy", {31'b0, busy}, 32'd0);
        issue(3'd0, 32'd3, 32'd4, 1'b1);

        // Asynchronous reset in the middle of a MULHU.
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (14) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("midop_reset_busy", {31'b0, busy}, 32'd0);
        check("midop_reset_done", {31'b0, done}, 32'd0);
        check("midop_reset_result", result, 32'd0);
        last_exp = '0;
        @(negedge CLK);
        RST_N = 1'b1;

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            issue(rf3, pick_operand(), pick_operand(), 1'b1);
        end

        // Drain the remaining expectations.
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        check("drain_pending", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
